// File: rtl/router_pkg.sv
// Shared router definitions: port indices, one-hot port codes, arbiter FSM
// states and the default downstream buffer depth.
package router_pkg;

  localparam int NUM_PORTS       = 5;
  localparam int DEFAULT_CREDITS = 4;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam logic [4:0] ONEHOT_N = 5'b00001;
  localparam logic [4:0] ONEHOT_E = 5'b00010;
  localparam logic [4:0] ONEHOT_W = 5'b00100;
  localparam logic [4:0] ONEHOT_S = 5'b01000;
  localparam logic [4:0] ONEHOT_L = 5'b10000;

  // IDLE: no owner, arbitrating. LOCKED: owner holds the output for a packet.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // One-hot code for a port index; out-of-range indices give all zeros.
  function automatic logic [4:0] port_onehot(input logic [2:0] p);
    port_onehot = 5'b00001 << p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`,
// wrapping from L back to N.
module rr_pick
  import router_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last,
  output logic [2:0] win,
  output logic       any
);

  // Scan the five ports starting one past the previous winner.
  always_comb begin
    int idx;
    idx = 0;
    win = 3'd0;
    any = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last) + i) % NUM_PORTS;
      if (!any && req[idx]) begin
        win = idx[2:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_arbiter.sv
// Credit-based wormhole output arbiter. One idle arbitration cycle picks an
// owner round-robin; the owner then keeps the output until its tail flit is
// granted. Flits only move while downstream credits are available.
//
// Handshake: a flit transfers in any cycle where grant[i] is high; grant[i]
// is high only when req[i] is high, i is the locked owner, and at least one
// credit remains. credit_in returns exactly one downstream slot per pulse.
module credit_arbiter
  import router_pkg::*;
#(
  parameter int CREDITS = DEFAULT_CREDITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       credit_in,
  output logic [4:0] grant,
  output logic [4:0] xbar_sel,
  output logic       valid_out,
  output logic [2:0] credit_cnt,
  output logic       credit_err,
  output state_e     state_dbg
);

  localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

  state_e     state, state_nxt;
  logic [2:0] owner;
  logic [2:0] last_winner;
  logic [2:0] rr_win;
  logic       rr_any;
  logic [4:0] owner_oh;
  logic       owner_req;
  logic       owner_tail;
  logic       flit_go;
  logic       tail_go;

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_winner),
    .win  (rr_win),
    .any  (rr_any)
  );

  assign owner_oh   = port_onehot(owner);
  assign owner_req  = |(req & owner_oh);
  assign owner_tail = |(tail & owner_oh);
  assign flit_go    = (state == ST_LOCKED) && owner_req && (credit_cnt != 3'd0);
  assign tail_go    = flit_go && owner_tail;
  assign valid_out  = |grant;
  assign state_dbg  = state;

  // Next-state and output decode; the arbitration cycle never grants.
  always_comb begin
    state_nxt = state;
    grant     = 5'b00000;
    xbar_sel  = 5'b00000;
    unique case (state)
      ST_IDLE: begin
        if (rr_any) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        xbar_sel = owner_oh;
        if (flit_go) grant = owner_oh;
        if (tail_go) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, owner capture and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      owner       <= PORT_N;
      last_winner <= PORT_L;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && rr_any) owner <= rr_win;
      if (tail_go) last_winner <= owner;
    end
  end

  // Credit counter: a grant and a returned credit in the same cycle cancel;
  // a return while already full is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      if (flit_go && !credit_in) begin
        credit_cnt <= credit_cnt - 3'd1;
      end else if (credit_in && !flit_go) begin
        if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
        else credit_cnt <= credit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed scoreboard bench for credit_arbiter (CREDITS = 4).
module tb_credit_arbiter;
  import router_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] grant;
  logic [4:0] xbar_sel;
  logic       valid_out;
  logic [2:0] credit_cnt;
  logic       credit_err;
  state_e     state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {grant, xbar_sel, credit_cnt} per driven cycle.
  logic [12:0] exp_q[$];

  credit_arbiter #(.CREDITS(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .xbar_sel   (xbar_sel),
    .valid_out  (valid_out),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), queue the expected
  // outputs, compare them at the falling edge, then move to the next cycle.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic ci,
                      input logic [4:0] eg, input logic [4:0] ex, input logic [2:0] ec);
    logic [12:0] e;
    req       = r;
    tail      = t;
    credit_in = ci;
    exp_q.push_back({eg, ex, ec});
    @(negedge clk);
    e = exp_q.pop_front();
    check_val("grant", 32'(grant), 32'(e[12:8]));
    check_val("xbar_sel", 32'(xbar_sel), 32'(e[7:3]));
    check_val("valid_out", 32'(valid_out), 32'(|e[12:8]));
    check_val("credit_cnt", 32'(credit_cnt), 32'(e[2:0]));
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously, check reset values at once, release.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_xbar", 32'(xbar_sel), 32'd0);
    check_val("rst_valid", 32'(valid_out), 32'd0);
    check_val("rst_cnt", 32'(credit_cnt), 32'd4);
    check_val("rst_err", 32'(credit_err), 32'd0);
    check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 5'b0;
    tail      = 5'b0;
    credit_in = 1'b0;
    #3;
    do_reset();

    // Single-flit N packet: arbitrate, grant, back to idle.
    step(5'b00001, 5'b00001, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b00001, 5'b00001, 1'b0, 5'b00001, 5'b00001, 3'd4);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd3);

    // Round-robin over all ports, single-flit packets, credit returned on grant.
    do_reset();
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b00001, 5'b00001, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b00010, 5'b00010, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b00100, 5'b00100, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b01000, 5'b01000, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b10000, 5'b10000, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b1, 5'b00001, 5'b00001, 3'd4);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    check_val("err_after_rr", 32'(credit_err), 32'd0);

    // Drain to 2 credits with two N packets (wrap back to N).
    step(5'b00001, 5'b00001, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b00001, 5'b00001, 1'b0, 5'b00001, 5'b00001, 3'd4);
    step(5'b00001, 5'b00001, 1'b0, 5'b00000, 5'b00000, 3'd3);
    step(5'b00001, 5'b00001, 1'b0, 5'b00001, 5'b00001, 3'd3);

    // E packet: grant+credit_in at 2 keeps 2, run out of credits, stall
    // with lock held, credit_in at 0 does not grant that cycle.
    step(5'b00010, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd2);
    step(5'b00010, 5'b00000, 1'b1, 5'b00010, 5'b00010, 3'd2);
    step(5'b00010, 5'b00000, 1'b0, 5'b00010, 5'b00010, 3'd2);
    step(5'b00010, 5'b00000, 1'b0, 5'b00010, 5'b00010, 3'd1);
    step(5'b00010, 5'b00010, 1'b0, 5'b00000, 5'b00010, 3'd0);
    step(5'b00010, 5'b00010, 1'b1, 5'b00000, 5'b00010, 3'd0);
    step(5'b00010, 5'b00010, 1'b0, 5'b00010, 5'b00010, 3'd1);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd0);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd1);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd2);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd3);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    check_val("err_before_ovf", 32'(credit_err), 32'd0);

    // W owns the output; W drops req for 3 cycles while N requests.
    step(5'b00101, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b00101, 5'b00000, 1'b0, 5'b00100, 5'b00100, 3'd4);
    step(5'b00001, 5'b00000, 1'b0, 5'b00000, 5'b00100, 3'd3);
    step(5'b00001, 5'b00000, 1'b0, 5'b00000, 5'b00100, 3'd3);
    step(5'b00001, 5'b00000, 1'b0, 5'b00000, 5'b00100, 3'd3);
    step(5'b00101, 5'b00100, 1'b0, 5'b00100, 5'b00100, 3'd3);

    // Refill, then overflow at full credits sets the sticky error.
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd2);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd3);
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 3'd4);
    check_val("err_set", 32'(credit_err), 32'd1);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    check_val("err_sticky", 32'(credit_err), 32'd1);

    // S mid-packet (last winner W), then asynchronous reset.
    step(5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 3'd4);
    step(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 3'd3);
    do_reset();
    step(5'b11111, 5'b11111, 1'b0, 5'b00000, 5'b00000, 3'd4);
    step(5'b11111, 5'b11111, 1'b0, 5'b00001, 5'b00001, 3'd4);
    step(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 3'd3);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/credit_arbiter.md
CREDIT_ARBITER -- requirements
Module: credit_arbiter

Interface
REQ-001 Parameter CREDITS, default 4, SHALL set the downstream buffer depth in flits (legal range 1..7).
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 req  input  5  is the per-requester flit-valid vector; bit0 N, bit1 E, bit2 W, bit3 S, bit4 L.
REQ-005 tail  input  5  SHALL mark, per requester, that its current head flit is a packet tail.
REQ-006 credit_in  input  1  SHALL be a one-cycle pulse returning one downstream buffer slot.
REQ-007 grant  output  5  is the one-hot flit-transfer grant; at most one bit SHALL be high.
REQ-008 xbar_sel  output  5  is the one-hot crossbar select of the locked owner, using the same bit order as req.
REQ-009 valid_out  output  1  SHALL equal the OR of grant.
REQ-010 credit_cnt  output  3  SHALL report the available downstream credits.
REQ-011 credit_err  output  1  is a sticky flag for credit overflow.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and LOCKED (owner held for the whole packet).
REQ-013 IDLE with req == 0 SHALL stay IDLE with grant = 0 and xbar_sel = 0.
REQ-014 IDLE with req != 0 SHALL select one winner round-robin, searching from the bit after last_winner upward and wrapping 4->0; next cycle SHALL be LOCKED with owner = winner.
REQ-015 The IDLE arbitration cycle SHALL never assert grant, so the first grant occurs no earlier than 1 cycle after req rises.
REQ-016 In LOCKED, xbar_sel SHALL equal the owner one-hot constantly, regardless of req or credits.
REQ-017 In LOCKED, grant[owner] SHALL be asserted combinationally iff req[owner] = 1 and credit_cnt > 0; all other grant bits SHALL be 0.
REQ-018 In LOCKED with req[owner] = 0, the lock SHALL be held (wormhole) and grant = 0; other requesters SHALL be ignored.
REQ-019 A granted flit with tail[owner] = 1 SHALL return the FSM to IDLE next cycle and set last_winner = owner.
REQ-020 A grant with tail[owner] = 0 SHALL keep LOCKED.
REQ-021 A single-flit packet (head = tail) SHALL take exactly one grant cycle, then return to IDLE.
REQ-022 credit_cnt SHALL decrement by 1 on a grant, increment by 1 on credit_in, and stay unchanged when both occur in the same cycle.
REQ-023 credit_in with credit_cnt = CREDITS and no grant SHALL leave credit_cnt unchanged and set credit_err until reset.
REQ-024 credit_cnt SHALL never underflow, which REQ-017 guarantees.
REQ-025 With credit_cnt = 0 and credit_in arriving, grant SHALL stay 0 that cycle and may assert the next cycle.
REQ-026 Back-to-back packets SHALL incur exactly one IDLE cycle between a tail grant and the next head grant.

Reset
REQ-027 When rst is asserted (rst = 0): state = IDLE, last_winner = L (N is highest priority first), credit_cnt = CREDITS, credit_err = 0, grant = 0, xbar_sel = 0, valid_out = 0.
REQ-028 Reset mid-packet SHALL drop the lock immediately, asynchronously, without any grant.
REQ-029 Deassertion of rst SHALL take effect at the first rising clk edge after rst returns high.

Structure
REQ-030 Shared package router_pkg SHALL hold the port index enum (N,E,W,S,L = 0..4), the one-hot port constants, the FSM state enum, and the default CREDITS value.
REQ-031 The round-robin search SHALL be a purely combinational sub-module rr_pick, with inputs req[4:0] and last[2:0] and outputs win[2:0] and any.
REQ-032 The FSM, owner, last_winner and credit counter SHALL reside in credit_arbiter.

Verification
REQ-033 Reset, then req = 5'b00001 with tail = 5'b00001 held: cycle 1 IDLE; cycle 2 grant = 5'b00001, xbar_sel = 5'b00001, credit_cnt 4->3; cycle 3 IDLE.
REQ-034 req = 5'b11111, all single-flit packets, credits replenished each cycle: the grant sequence SHALL be N, E, W, S, L, N, with one IDLE cycle between grants.
REQ-035 E locked, 3-flit packet, no credit_in, CREDITS = 2: two grants, then grant = 0 with xbar_sel = 5'b00010 held; a credit_in pulse produces the third (tail) grant on the next cycle.
REQ-036 Owner W drops req for 3 cycles mid-packet while req[N] = 1: N SHALL never be granted, xbar_sel SHALL stay 5'b00100, and W resumes when its req rises again.
REQ-037 Grant and credit_in in the same cycle with credit_cnt = 2 SHALL leave credit_cnt = 2; credit_in at credit_cnt = 4 with no grant SHALL set credit_err = 1, which stays set until reset.
REQ-038 Asserting rst = 0 mid-packet for S SHALL immediately give grant = 0, xbar_sel = 0, credit_cnt = 4; after release, req = 5'b11111 SHALL first grant N.
